// File: rtl/lsu_avm_pipe_stage.sv
// Registered Avalon-MM stage on the wide-LSU master port.
// Two-entry command skid buffer, one response register, read-credit cap.
//
// Ports:
//   clock, resetn      clock, async active-low reset
//   s_*                upstream slave side (from the LSU master)
//   m_*                downstream master side (to the interconnect)
//   o_pending          outstanding read words
// Optional build macro LSU_AVM_PIPE_PROFILE_EN adds stall counters
//   o_prof_credit_stall, o_prof_wait_stall.
module lsu_avm_pipe_stage #(
  parameter int AWIDTH           = 32,
  parameter int MWIDTH_BYTES     = 32,
  parameter int BURSTCOUNT_WIDTH = 6,
  parameter int MAX_PENDING      = 64,
  localparam int MWIDTH          = 8 * MWIDTH_BYTES,
  localparam int PW              = $clog2(MAX_PENDING + 1)
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic [AWIDTH-1:0]           s_address,
  input  logic                        s_read,
  input  logic                        s_write,
  input  logic [MWIDTH-1:0]           s_writedata,
  input  logic [MWIDTH_BYTES-1:0]     s_byteenable,
  input  logic [BURSTCOUNT_WIDTH-1:0] s_burstcount,
  output logic                        s_waitrequest,
  output logic [MWIDTH-1:0]           s_readdata,
  output logic                        s_readdatavalid,
  output logic                        s_writeack,
  output logic [AWIDTH-1:0]           m_address,
  output logic                        m_read,
  output logic                        m_write,
  output logic [MWIDTH-1:0]           m_writedata,
  output logic [MWIDTH_BYTES-1:0]     m_byteenable,
  output logic [BURSTCOUNT_WIDTH-1:0] m_burstcount,
  input  logic                        m_waitrequest,
  input  logic [MWIDTH-1:0]           m_readdata,
  input  logic                        m_readdatavalid,
  input  logic                        m_writeack,
  output logic [PW-1:0]               o_pending
`ifdef LSU_AVM_PIPE_PROFILE_EN
  ,
  output logic [31:0]                 o_prof_credit_stall,
  output logic [31:0]                 o_prof_wait_stall
`endif
);

  typedef struct packed {
    logic                        rd;
    logic                        wr;
    logic [AWIDTH-1:0]           addr;
    logic [MWIDTH-1:0]           data;
    logic [MWIDTH_BYTES-1:0]     be;
    logic [BURSTCOUNT_WIDTH-1:0] burst;
  } cmd_t;

  cmd_t in_cmd;
  cmd_t m_q;
  cmd_t s_q;
  logic m_valid;
  logic s_valid;
  logic accept;
  logic m_adv;
  logic credit_ok;
  logic rd_issue;
  logic [31:0] credit_sum;
  logic [PW:0] inc;
  logic [PW:0] sum;
  logic [PW:0] nxt;

  assign in_cmd = '{
    rd:    s_read,
    wr:    s_write,
    addr:  s_address,
    data:  s_writedata,
    be:    s_byteenable,
    burst: s_burstcount
  };

  // Waitrequest comes straight from the skid flop, so it is
  // registered and isolated from m_waitrequest.
  assign s_waitrequest = s_valid;
  assign accept = (s_read | s_write) & ~s_valid;

  assign credit_sum = 32'(o_pending) + 32'(m_q.burst);
  assign credit_ok  = credit_sum <= 32'(MAX_PENDING);

  assign m_read  = m_valid & m_q.rd & credit_ok;
  assign m_write = m_valid & m_q.wr;

  assign m_address    = m_q.addr;
  assign m_writedata  = m_q.data;
  assign m_byteenable = m_q.be;
  assign m_burstcount = m_q.burst;

  assign m_adv    = ~m_valid | ((m_read | m_write) & ~m_waitrequest);
  assign rd_issue = m_read & ~m_waitrequest;

  // accept implies the skid is empty, so when M advances from S
  // there is never a new beat to capture in the same cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_q     <= '0;
      s_q     <= '0;
    end else if (m_adv) begin
      if (s_valid) begin
        m_q     <= s_q;
        m_valid <= 1'b1;
        s_valid <= 1'b0;
      end else if (accept) begin
        m_q     <= in_cmd;
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (accept) begin
      s_q     <= in_cmd;
      s_valid <= 1'b1;
    end
  end

  // Net pending change applied in one step; an unmatched return
  // saturates at zero instead of wrapping.
  always_comb begin
    inc = '0;
    if (rd_issue) begin
      inc = (PW+1)'(m_q.burst);
    end
    sum = {1'b0, o_pending} + inc;
    nxt = sum;
    if (m_readdatavalid) begin
      nxt = (sum == '0) ? '0 : sum - (PW+1)'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      o_pending <= '0;
    end else begin
      o_pending <= PW'(nxt);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s_readdata      <= '0;
      s_readdatavalid <= 1'b0;
      s_writeack      <= 1'b0;
    end else begin
      s_readdata      <= m_readdata;
      s_readdatavalid <= m_readdatavalid;
      s_writeack      <= m_writeack;
    end
  end

`ifdef LSU_AVM_PIPE_PROFILE_EN
  logic [31:0] credit_stall_q;
  logic [31:0] wait_stall_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      credit_stall_q <= '0;
      wait_stall_q   <= '0;
    end else begin
      if (m_valid & m_q.rd & ~credit_ok) begin
        credit_stall_q <= credit_stall_q + 32'd1;
      end
      if ((m_read | m_write) & m_waitrequest) begin
        wait_stall_q <= wait_stall_q + 32'd1;
      end
    end
  end

  assign o_prof_credit_stall = credit_stall_q;
  assign o_prof_wait_stall   = wait_stall_q;
`else
`endif

`ifndef SYNTHESIS
  a_no_orphan_return : assert property (
    @(posedge clock) disable iff (!resetn)
    !(m_readdatavalid && o_pending == '0 && !rd_issue)
  );
`endif

endmodule

// File: tb/tb_lsu_avm_pipe_stage.sv
// Scoreboard bench for lsu_avm_pipe_stage.
// Directed command/response traffic; monitor checks m_ side and responses.
module tb_lsu_avm_pipe_stage;
  localparam int AW = 32;
  localparam int MB = 32;
  localparam int MW = 8 * MB;
  localparam int BW = 6;
  localparam int MP = 64;
  localparam int PW = $clog2(MP + 1);

  logic          clock;
  logic          resetn;
  logic [AW-1:0] s_address;
  logic          s_read;
  logic          s_write;
  logic [MW-1:0] s_writedata;
  logic [MB-1:0] s_byteenable;
  logic [BW-1:0] s_burstcount;
  logic          s_waitrequest;
  logic [MW-1:0] s_readdata;
  logic          s_readdatavalid;
  logic          s_writeack;
  logic [AW-1:0] m_address;
  logic          m_read;
  logic          m_write;
  logic [MW-1:0] m_writedata;
  logic [MB-1:0] m_byteenable;
  logic [BW-1:0] m_burstcount;
  logic          m_waitrequest;
  logic [MW-1:0] m_readdata;
  logic          m_readdatavalid;
  logic          m_writeack;
  logic [PW-1:0] o_pending;
`ifdef LSU_AVM_PIPE_PROFILE_EN
  logic [31:0]   o_prof_credit_stall;
  logic [31:0]   o_prof_wait_stall;
`endif

  lsu_avm_pipe_stage #(
    .AWIDTH(AW),
    .MWIDTH_BYTES(MB),
    .BURSTCOUNT_WIDTH(BW),
    .MAX_PENDING(MP)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .s_address(s_address),
    .s_read(s_read),
    .s_write(s_write),
    .s_writedata(s_writedata),
    .s_byteenable(s_byteenable),
    .s_burstcount(s_burstcount),
    .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .s_writeack(s_writeack),
    .m_address(m_address),
    .m_read(m_read),
    .m_write(m_write),
    .m_writedata(m_writedata),
    .m_byteenable(m_byteenable),
    .m_burstcount(m_burstcount),
    .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .m_writeack(m_writeack),
    .o_pending(o_pending)
`ifdef LSU_AVM_PIPE_PROFILE_EN
    ,
    .o_prof_credit_stall(o_prof_credit_stall),
    .o_prof_wait_stall(o_prof_wait_stall)
`endif
  );

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [MW-1:0] d;
    logic [MB-1:0] be;
    logic [BW-1:0] b;
  } exp_t;

  exp_t          cq[$];
  logic [MW-1:0] rq[$];
  int checks;
  int errors;
  logic prev_rdv;
  logic prev_wack;
  exp_t me;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string n,
                     input logic [511:0] act,
                     input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", n, act, exp);
    end
  endtask

  task automatic bad(input string n);
    checks++;
    errors++;
    $display("FAIL %s act=event exp=none", n);
  endtask

  function automatic logic [MB-1:0] be_of(input logic [AW-1:0] a);
    return {MB{1'b1}} ^ MB'(a);
  endfunction

  task automatic idle();
    s_read  = 1'b0;
    s_write = 1'b0;
  endtask

  task automatic issue(input logic w,
                       input logic [AW-1:0] a,
                       input logic [MW-1:0] d,
                       input logic [BW-1:0] b);
    exp_t e;
    bit ok;
    ok = 1'b0;
    s_read       = ~w;
    s_write      = w;
    s_address    = a;
    s_writedata  = w ? d : '0;
    s_byteenable = w ? be_of(a) : '0;
    s_burstcount = b;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (!s_waitrequest) begin
        ok = 1'b1;
        break;
      end
      @(posedge clock);
      #1;
    end
    if (ok) begin
      e.w  = w;
      e.a  = a;
      e.d  = d;
      e.be = be_of(a);
      e.b  = b;
      cq.push_back(e);
      @(posedge clock);
      #1;
    end else begin
      bad("issue_timeout");
      idle();
    end
  endtask

  task automatic ret(input logic [MW-1:0] d);
    m_readdatavalid = 1'b1;
    m_readdata      = d;
    rq.push_back(d);
    @(posedge clock);
    #1;
    m_readdatavalid = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!resetn) begin
      prev_rdv  = 1'b0;
      prev_wack = 1'b0;
    end else begin
      chk("rdv_delay", 512'(s_readdatavalid), 512'(prev_rdv));
      chk("wack_delay", 512'(s_writeack), 512'(prev_wack));
      if (s_readdatavalid) begin
        if (rq.size() == 0) bad("rdata_extra");
        else chk("rdata", 512'(s_readdata), 512'(rq.pop_front()));
      end
      if ((m_read || m_write) && !m_waitrequest) begin
        if (cq.size() == 0) begin
          bad("cmd_extra");
        end else begin
          me = cq.pop_front();
          chk("cmd_wr", 512'(m_write), 512'(me.w));
          chk("cmd_rd", 512'(m_read), 512'(!me.w));
          chk("cmd_addr", 512'(m_address), 512'(me.a));
          chk("cmd_burst", 512'(m_burstcount), 512'(me.b));
          if (me.w) begin
            chk("cmd_data", 512'(m_writedata), 512'(me.d));
            chk("cmd_be", 512'(m_byteenable), 512'(me.be));
          end
        end
      end
      prev_rdv  = m_readdatavalid;
      prev_wack = m_writeack;
    end
  end

  task automatic chk_reset_outs(input string n);
    chk({n, "_swait"}, 512'(s_waitrequest), 512'(0));
    chk({n, "_mread"}, 512'(m_read), 512'(0));
    chk({n, "_mwrite"}, 512'(m_write), 512'(0));
    chk({n, "_srdv"}, 512'(s_readdatavalid), 512'(0));
    chk({n, "_swack"}, 512'(s_writeack), 512'(0));
    chk({n, "_pend"}, 512'(o_pending), 512'(0));
    chk({n, "_maddr"}, 512'(m_address), 512'(0));
    chk({n, "_rdata"}, 512'(s_readdata), 512'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    s_address = '0;
    s_read = 1'b0;
    s_write = 1'b0;
    s_writedata = '0;
    s_byteenable = '0;
    s_burstcount = '0;
    m_waitrequest = 1'b0;
    m_readdata = '0;
    m_readdatavalid = 1'b0;
    m_writeack = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk_reset_outs("rst");
    resetn = 1'b1;

    // 1: single read burst 4, then 4 returns
    issue(1'b0, 32'h100, '0, 6'd4);
    idle();
    @(negedge clock);
    chk("t1_mread", 512'(m_read), 512'(1));
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("t1_pend4", 512'(o_pending), 512'(4));
    chk("t1_mread_off", 512'(m_read), 512'(0));
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) ret(MW'(32'hA000 + i));
    @(negedge clock);
    chk("t1_pend0", 512'(o_pending), 512'(0));

    // 2: three writes under 5 cycles of waitrequest
    @(posedge clock);
    #1;
    m_waitrequest = 1'b1;
    fork
      begin
        repeat (5) @(posedge clock);
        #1;
        m_waitrequest = 1'b0;
      end
    join_none
    issue(1'b1, 32'h200, MW'(32'hAAAA), 6'd3);
    issue(1'b1, 32'h240, MW'(32'hBBBB), 6'd3);
    idle();
    @(negedge clock);
    chk("t2_swait", 512'(s_waitrequest), 512'(1));
    chk("t2_mwrite", 512'(m_write), 512'(1));
    @(posedge clock);
    #1;
    issue(1'b1, 32'h280, MW'(32'hCCCC), 6'd3);
    idle();
    repeat (4) @(posedge clock);
    #1;
    m_writeack = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    m_writeack = 1'b0;
    @(negedge clock);
    chk("t2_drain", 512'(cq.size()), 512'(0));
    chk("t2_pend", 512'(o_pending), 512'(0));

    // 4: issue burst 8 together with one return at pending 10
    @(posedge clock);
    #1;
    issue(1'b0, 32'h300, '0, 6'd10);
    idle();
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("t4_pend10", 512'(o_pending), 512'(10));
    @(posedge clock);
    #1;
    issue(1'b0, 32'h340, '0, 6'd8);
    idle();
    m_readdatavalid = 1'b1;
    m_readdata = MW'(32'hB001);
    rq.push_back(MW'(32'hB001));
    @(negedge clock);
    chk("t4_mread", 512'(m_read), 512'(1));
    chk("t4_pend_pre", 512'(o_pending), 512'(10));
    @(posedge clock);
    #1;
    m_readdatavalid = 1'b0;
    @(negedge clock);
    chk("t4_pend17", 512'(o_pending), 512'(17));

    // 5: reset with M and S full, pending 20
    @(posedge clock);
    #1;
    issue(1'b0, 32'h380, '0, 6'd3);
    idle();
    @(posedge clock);
    #1;
    m_waitrequest = 1'b1;
    issue(1'b1, 32'h3C0, MW'(32'hDDDD), 6'd2);
    issue(1'b1, 32'h400, MW'(32'hEEEE), 6'd2);
    idle();
    @(negedge clock);
    chk("t5_swait", 512'(s_waitrequest), 512'(1));
    chk("t5_mwrite", 512'(m_write), 512'(1));
    chk("t5_pend20", 512'(o_pending), 512'(20));
    @(posedge clock);
    #1;
    resetn = 1'b0;
    cq.delete();
    rq.delete();
    #1;
    chk_reset_outs("t5");
    m_waitrequest = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("t5_nostrobe", 512'(m_read | m_write), 512'(0));
      chk("t5_swait0", 512'(s_waitrequest), 512'(0));
    end

    // 3: credit cap; third burst-32 read waits for pending <= 32
    @(posedge clock);
    #1;
    issue(1'b0, 32'h500, '0, 6'd32);
    issue(1'b0, 32'h600, '0, 6'd32);
    issue(1'b0, 32'h700, '0, 6'd32);
    idle();
    @(negedge clock);
    chk("t3_held", 512'(m_read), 512'(0));
    chk("t3_pend64", 512'(o_pending), 512'(64));
    @(posedge clock);
    #1;
    issue(1'b1, 32'h800, MW'(32'hFFFF), 6'd1);
    idle();
    @(negedge clock);
    chk("t3_swait", 512'(s_waitrequest), 512'(1));
    chk("t3_wblock", 512'(m_write), 512'(0));
    @(posedge clock);
    #1;
    for (int i = 0; i < 32; i++) begin
      m_readdatavalid = 1'b1;
      m_readdata = MW'(32'hC000 + i);
      rq.push_back(MW'(32'hC000 + i));
      @(negedge clock);
      chk("t3_hold", 512'(m_read), 512'(0));
      @(posedge clock);
      #1;
    end
    m_readdatavalid = 1'b0;
    @(negedge clock);
    chk("t3_issue", 512'(m_read), 512'(1));
    chk("t3_pend32", 512'(o_pending), 512'(32));
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("t3_wafter", 512'(m_write), 512'(1));
    chk("t3_pend64b", 512'(o_pending), 512'(64));
    repeat (3) @(posedge clock);
    #1;

`ifdef LSU_AVM_PIPE_PROFILE_EN
    // 6: stall counters, 3 waitrequest cycles then 7 credit stalls
    resetn = 1'b0;
    cq.delete();
    rq.delete();
    #1;
    chk("t6_cs0", 512'(o_prof_credit_stall), 512'(0));
    chk("t6_ws0", 512'(o_prof_wait_stall), 512'(0));
    @(posedge clock);
    #1;
    resetn = 1'b1;
    m_waitrequest = 1'b1;
    issue(1'b1, 32'h900, MW'(32'h1), 6'd1);
    idle();
    repeat (3) @(posedge clock);
    #1;
    m_waitrequest = 1'b0;
    @(negedge clock);
    chk("t6_ws3", 512'(o_prof_wait_stall), 512'(3));
    @(posedge clock);
    #1;
    issue(1'b0, 32'hA00, '0, 6'd32);
    issue(1'b0, 32'hB00, '0, 6'd32);
    issue(1'b0, 32'hC00, '0, 6'd32);
    idle();
    repeat (7) @(posedge clock);
    #1;
    chk("t6_cs7", 512'(o_prof_credit_stall), 512'(7));
    chk("t6_ws3b", 512'(o_prof_wait_stall), 512'(3));
    resetn = 1'b0;
    cq.delete();
    #1;
    @(posedge clock);
    #1;
    resetn = 1'b1;
`endif

    repeat (3) @(posedge clock);
    #1;
    chk("end_cq", 512'(cq.size()), 512'(0));
    chk("end_rq", 512'(rq.size()), 512'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
